// File: rtl/regchk_pkg.sv
// regchk_pkg: shared state encoding, trace entry layout and default parameters for regfile_checker
package regchk_pkg;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_CYC_W       = 12;
    localparam int DEF_TRACE_DEPTH = 16;
    localparam int DEF_SKIP_R0     = 1;
    localparam int DEF_REG_AW      = $clog2(DEF_NUM_REGS);
    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
    typedef struct packed {
        logic [DEF_CYC_W-1:0]  cycle;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } trace_t;
endpackage

// File: rtl/regchk_trace_fifo.sv
// regchk_trace_fifo: synchronous trace FIFO; a push at full is accepted when a pop frees a slot in the same cycle
module regchk_trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_pop;
    logic         w_push;
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rp[AW-1:0]];
    // storage has no reset: only slots between the pointers are ever read
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end
    // pointers carry a wrap bit so full and empty are distinguishable
    always_ff @(posedge i_clock) begin
        if (!i_reset || i_clr) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop) r_rp <= r_rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/regfile_checker.sv
// regfile_checker: run-cycle counter, writeback trace (REGCHK_TRACE_EN) and register dump compare against an expected ROM
module regfile_checker
    import regchk_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int REG_AW      = $clog2(NUM_REGS),
    parameter int CYC_W       = DEF_CYC_W,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
    parameter int SKIP_R0     = DEF_SKIP_R0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [CYC_W-1:0]  i_run_cycles,
    input  logic              i_rwe,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [REG_AW-1:0] i_cpu_rs1,
    output logic [REG_AW-1:0] o_rs1_out,
    input  logic [DATA_W-1:0] i_rega,
    output logic [REG_AW-1:0] o_exp_addr,
    input  logic [DATA_W-1:0] i_exp_data,
    output logic              o_trace_valid,
    input  logic              i_trace_ready,
    output logic [CYC_W-1:0]  o_trace_cycle,
    output logic [REG_AW-1:0] o_trace_rd,
    output logic [DATA_W-1:0] o_trace_data,
    output logic              o_trace_overflow,
    output logic              o_test_mode,
    output logic              o_mm_valid,
    output logic [REG_AW-1:0] o_mm_reg,
    output logic [REG_AW:0]   o_error_count,
    output logic              o_done,
    output logic              o_pass
);
    localparam logic [REG_AW:0] LAST = (REG_AW+1)'(NUM_REGS);
    state_t              r_state;
    state_t              w_next;
    logic [CYC_W-1:0]    r_run;
    logic [CYC_W-1:0]    r_cyc;
    logic [REG_AW:0]     r_idx;
    logic [REG_AW:0]     r_err;
    logic [REG_AW-1:0]   r_cidx;
    logic [DATA_W-1:0]   r_rega;
    logic                r_cmp;
    logic                w_start;
    logic                w_push;
    logic                w_mm;
    assign w_start       = i_start && (r_state == IDLE || r_state == DONE);
    assign w_push        = r_state == RUN && i_rwe && !(SKIP_R0 != 0 && i_rd == '0);
    assign w_mm          = r_cmp && (r_rega != i_exp_data);
    assign o_mm_valid    = w_mm;
    assign o_mm_reg      = w_mm ? r_cidx : '0;
    assign o_error_count = r_err;
    assign o_test_mode   = r_state == DUMP;
    assign o_done        = r_state == DONE;
    assign o_pass        = o_done && r_err == '0;
    // state register
    always_ff @(posedge i_clock) begin
        r_state <= !i_reset ? IDLE : w_next;
    end
    // next state and port-A / ROM address steering
    always_comb begin
        w_next     = r_state;
        o_rs1_out  = i_cpu_rs1;
        o_exp_addr = '0;
        case (r_state)
            IDLE, DONE: w_next = !i_start ? r_state : (i_run_cycles == '0) ? DUMP : RUN;
            RUN:        w_next = (r_cyc == r_run - CYC_W'(1)) ? DUMP : RUN;
            DUMP: begin
                o_rs1_out  = r_idx[REG_AW-1:0];
                o_exp_addr = r_idx[REG_AW-1:0];
                w_next     = (r_idx == LAST) ? DONE : DUMP;
            end
            default:    w_next = IDLE;
        endcase
    end
    // run/dump counters, one-stage compare pipeline aligned to ROM latency, saturating error count
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_run  <= '0;
            r_cyc  <= '0;
            r_idx  <= '0;
            r_err  <= '0;
            r_cmp  <= 1'b0;
            r_cidx <= '0;
            r_rega <= '0;
        end else begin
            r_cmp  <= r_state == DUMP && r_idx != LAST;
            r_cidx <= r_idx[REG_AW-1:0];
            r_rega <= i_rega;
            if (w_start) begin
                r_run <= i_run_cycles;
                r_cyc <= '0;
                r_idx <= '0;
                r_err <= '0;
            end else begin
                if (r_state == RUN) r_cyc <= r_cyc + CYC_W'(1);
                if (r_state == DUMP) r_idx <= r_idx + (REG_AW+1)'(1);
                if (w_mm && r_err != '1) r_err <= r_err + (REG_AW+1)'(1);
            end
        end
    end
`ifdef REGCHK_TRACE_EN
    logic                            w_empty;
    logic                            w_full;
    logic                            r_ovf;
    logic [CYC_W+REG_AW+DATA_W-1:0]  w_head;
    regchk_trace_fifo #(
        .W     (CYC_W + REG_AW + DATA_W),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (w_start),
        .i_push  (w_push),
        .i_pop   (i_trace_ready),
        .i_data  ({r_cyc, i_rd, i_rdata}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // overflow stays set until reset or the next run; full implies non-empty so a pop is just trace_ready
    always_ff @(posedge i_clock) begin
        if (!i_reset || w_start) r_ovf <= 1'b0;
        else if (w_push && w_full && !i_trace_ready) r_ovf <= 1'b1;
    end
    assign o_trace_valid                          = !w_empty;
    assign {o_trace_cycle, o_trace_rd, o_trace_data} = w_head;
    assign o_trace_overflow                       = r_ovf;
`else
    logic w_unused;
    assign w_unused         = ^{w_push, i_trace_ready, i_rdata, TRACE_DEPTH[0]};
    assign o_trace_valid    = 1'b0;
    assign o_trace_cycle    = '0;
    assign o_trace_rd       = '0;
    assign o_trace_data     = '0;
    assign o_trace_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_checker.sv
// tb_regfile_checker: directed checks of run length, trace FIFO, dump compare, reset abort and zero-length run
module tb_regfile_checker;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 12;
    localparam int TD = 4;
`ifdef REGCHK_TRACE_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rwe = 1'b0;
    logic          trace_ready = 1'b0;
    logic [CW-1:0] run_cycles = '0;
    logic [AW-1:0] rd = '0;
    logic [AW-1:0] cpu_rs1 = '0;
    logic [DW-1:0] rdata = '0;
    logic [AW-1:0] rs1_out, exp_addr, trace_rd, mm_reg;
    logic [DW-1:0] rega, exp_data, trace_data;
    logic [CW-1:0] trace_cycle;
    logic          trace_valid, trace_overflow, test_mode, mm_valid, done, pass;
    logic [AW:0]   error_count;
    logic [DW-1:0] rf [NR];
    logic [DW-1:0] rom [NR];
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int mm_cnt = 0;
    int mm0 = 0;

    regfile_checker #(
        .DATA_W(DW), .NUM_REGS(NR), .CYC_W(CW), .TRACE_DEPTH(TD), .SKIP_R0(1)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_run_cycles(run_cycles),
        .i_rwe(rwe), .i_rd(rd), .i_rdata(rdata), .i_cpu_rs1(cpu_rs1),
        .o_rs1_out(rs1_out), .i_rega(rega), .o_exp_addr(exp_addr), .i_exp_data(exp_data),
        .o_trace_valid(trace_valid), .i_trace_ready(trace_ready), .o_trace_cycle(trace_cycle),
        .o_trace_rd(trace_rd), .o_trace_data(trace_data), .o_trace_overflow(trace_overflow),
        .o_test_mode(test_mode), .o_mm_valid(mm_valid), .o_mm_reg(mm_reg),
        .o_error_count(error_count), .o_done(done), .o_pass(pass)
    );

    always #5 clk = ~clk;
    assign rega = rf[rs1_out];
    always @(posedge clk) exp_data <= rom[exp_addr];
    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < NR; i++) rf[i] <= 32'hA500_0000 | DW'(i);
        else if (rwe) rf[rd] <= rdata;
    end
    always @(negedge clk) if (mm_valid) mm_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) rom[i] = 32'hA500_0000 | DW'(i);
        rom[3] = 32'd7;
        rom[0] = 32'd9;
        cpu_rs1 = 5'd5;
        tick(2);
        chk("rst_rs1_out", rs1_out, 5);
        chk("rst_exp_addr", exp_addr, 0);
        chk("rst_trace", {trace_valid, trace_overflow}, 0);
        chk("rst_test_mode", test_mode, 0);
        chk("rst_mm", {mm_valid, mm_reg}, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_done_pass", {done, pass}, 0);
        rst_n = 1'b1;
        tick(1);
        // run of 5 cycles, r3=7 at cycle 1, r0=9 at cycle 2, ROM matches
        mm0 = mm_cnt;
        start = 1'b1; run_cycles = 12'd5;
        tick(1);
        start = 1'b0;
        chk("run_test_mode", test_mode, 0);
        chk("run_rs1_follows_cpu", rs1_out, 5);
        tick(1);
        rwe = 1'b1; rd = 5'd3; rdata = 32'd7;
        tick(1);
        rd = 5'd0; rdata = 32'd9;
        chk("trace_valid", trace_valid, TEN);
        chk("trace_head", {trace_cycle, trace_rd, trace_data}, TEN ? {12'd1, 5'd3, 32'd7} : '0);
        tick(1);
        rwe = 1'b0;
        tick(1);
        chk("run_len_test_mode_lo", test_mode, 0);
        tick(1);
        chk("dump_entry_test_mode", test_mode, 1);
        chk("dump_idx0", {rs1_out, exp_addr}, 0);
        trace_ready = 1'b1;
        tick(1);
        trace_ready = 1'b0;
        chk("trace_single_entry", trace_valid, 0);
        tick(9);
        chk("dump_idx10", {rs1_out, exp_addr}, {5'd10, 5'd10});
        tick(22);
        chk("done_not_early", done, 0);
        tick(1);
        chk("done_pass", {done, pass}, 2'b11);
        chk("pass_error_count", error_count, 0);
        chk("no_mm_pulses", mm_cnt - mm0, 0);
        chk("done_rs1_follows_cpu", rs1_out, 5);
        // restart from DONE, ROM differs at r4 and r31
        rom[4] = rom[4] ^ 32'd1;
        rom[31] = rom[31] ^ 32'hFFFF_0000;
        start = 1'b1; run_cycles = 12'd1;
        tick(1);
        start = 1'b0;
        chk("restart_run", {test_mode, done}, 0);
        tick(1);
        chk("rc1_dump", test_mode, 1);
        tick(4);
        chk("mm_before_r4", mm_valid, 0);
        tick(1);
        chk("mm_r4", {mm_valid, mm_reg}, {1'b1, 5'd4});
        chk("mm_lag_index", rs1_out, 5);
        tick(1);
        chk("mm_r4_clears", {mm_valid, error_count}, {1'b0, 6'd1});
        tick(26);
        chk("mm_r31", {mm_valid, mm_reg}, {1'b1, 5'd31});
        tick(1);
        chk("fail_done", {done, pass, error_count}, {1'b1, 1'b0, 6'd2});
        // overflow: six writes into a 4-deep FIFO, then a push with pop at full
        start = 1'b1; run_cycles = 12'd10;
        tick(1);
        start = 1'b0;
        chk("restart_clears_errors", error_count, 0);
        for (int i = 1; i <= 6; i++) begin
            rwe = 1'b1; rd = AW'(i); rdata = 32'h100 + DW'(i);
            tick(1);
        end
        chk("ovf_set", trace_overflow, TEN);
        chk("ovf_head", {trace_valid, trace_cycle, trace_rd, trace_data}, TEN ? {1'b1, 12'd0, 5'd1, 32'h101} : '0);
        rd = 5'd7; rdata = 32'h107; trace_ready = 1'b1;
        tick(1);
        rwe = 1'b0;
        chk("pop_head2", {trace_valid, trace_rd}, TEN ? {1'b1, 5'd2} : '0);
        tick(2);
        chk("pop_head4", {trace_valid, trace_cycle, trace_rd}, TEN ? {1'b1, 12'd3, 5'd4} : '0);
        tick(1);
        chk("full_push_accepted", {trace_valid, trace_cycle, trace_rd, trace_data}, TEN ? {1'b1, 12'd6, 5'd7, 32'h107} : '0);
        tick(1);
        trace_ready = 1'b0;
        chk("fifo_drained", {trace_valid, trace_overflow}, TEN ? 2'b01 : 2'b00);
        // reset in mid-DUMP
        tick(5);
        cpu_rs1 = 5'd9;
        chk("pre_reset_dump", {test_mode, rs1_out}, {1'b1, 5'd6});
        rst_n = 1'b0;
        tick(1);
        chk("abort_state", {test_mode, done, pass}, 0);
        chk("abort_rs1", {rs1_out, exp_addr}, {5'd9, 5'd0});
        chk("abort_trace", {trace_valid, trace_overflow}, 0);
        chk("abort_mm_err", {mm_valid, mm_reg, error_count}, 0);
        // zero-length run goes straight to DUMP
        rst_n = 1'b1;
        tick(1);
        start = 1'b1; run_cycles = 12'd0;
        tick(1);
        start = 1'b0;
        chk("rc0_skip_run", {test_mode, rs1_out, exp_addr}, {1'b1, 5'd0, 5'd0});
        tick(1);
        chk("rc0_idx1", rs1_out, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
